// File: rtl/fifo_frame_unpacker.sv
// fifo_frame_unpacker: reads length-tagged frame words from the read side of the
// clock-crossing FIFO and streams their payload as valid/ready beats.
//
// state | meaning
// IDLE  | no word held; pops as soon as the FIFO is non-empty
// CAP   | popped word is on data_from_fifo; latch it or drop it for a bad length
// SEND  | emitting beats of the held word, least significant beat first
module fifo_frame_unpacker #(
   parameter int DATA_W    = 140,
   parameter int BEAT_W    = 16,
   parameter int MAX_BEATS = 8,
   parameter int CNT_W     = 16
) (
   input  logic              clk_out,
   input  logic              rst_n,
   input  logic              fifo_empty,
   output logic              fifo_r_enable,
   input  logic [DATA_W-1:0] data_from_fifo,
   output logic [BEAT_W-1:0] beat_data,
   output logic [7:0]        beat_chan,
   output logic              beat_last,
   output logic              beat_valid,
   input  logic              beat_ready,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  len_err_cnt,
   output logic              len_err
);
   localparam int         PAY_W   = MAX_BEATS * BEAT_W;
   localparam int         IDX_W   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam logic [3:0] MAX_LEN = 4'(MAX_BEATS);

   typedef enum logic [1:0] {S_IDLE, S_CAP, S_SEND} state_t;

   state_t            state;
   logic [PAY_W-1:0]  payload_q;
   logic [IDX_W-1:0]  beat_idx;
   logic [IDX_W-1:0]  last_idx;
   logic [IDX_W-1:0]  next_idx;
   logic [BEAT_W-1:0] beats [MAX_BEATS];
   logic [3:0]        new_len;
   logic              len_bad;
   logic              pop;

   assign new_len  = data_from_fifo[DATA_W-1 -: 4];
   assign len_bad  = (new_len == 4'd0) || (new_len > MAX_LEN);
   assign next_idx = beat_idx + IDX_W'(1);

   // A pop is offered either from IDLE or on the accepted last beat, so the next
   // word lands in CAP with a single bubble between frames.
   assign pop = rst_n && !fifo_empty &&
                ((state == S_IDLE) || (state == S_SEND && beat_ready && beat_last));
   assign fifo_r_enable = pop;

   always_comb begin
      for (int i = 0; i < MAX_BEATS; i++) begin
         beats[i] = payload_q[i*BEAT_W +: BEAT_W];
      end
   end

   always_ff @(posedge clk_out) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         payload_q   <= '0;
         beat_idx    <= '0;
         last_idx    <= '0;
         beat_data   <= '0;
         beat_chan   <= '0;
         beat_last   <= 1'b0;
         beat_valid  <= 1'b0;
         frame_cnt   <= '0;
         len_err_cnt <= '0;
         len_err     <= 1'b0;
      end else begin
         len_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) state <= S_CAP;
            end
            S_CAP: begin
               if (len_bad) begin
                  len_err <= 1'b1;
                  if (len_err_cnt != '1) len_err_cnt <= len_err_cnt + CNT_W'(1);
                  state <= S_IDLE;
               end else begin
                  payload_q  <= data_from_fifo[PAY_W-1:0];
                  beat_idx   <= '0;
                  last_idx   <= IDX_W'(new_len - 4'd1);
                  beat_data  <= data_from_fifo[BEAT_W-1:0];
                  beat_chan  <= data_from_fifo[DATA_W-5 -: 8];
                  beat_last  <= (new_len == 4'd1);
                  beat_valid <= 1'b1;
                  state      <= S_SEND;
               end
            end
            S_SEND: begin
               if (beat_ready) begin
                  if (beat_last) begin
                     frame_cnt  <= frame_cnt + CNT_W'(1);
                     beat_valid <= 1'b0;
                     beat_last  <= 1'b0;
                     state      <= pop ? S_CAP : S_IDLE;
                  end else begin
                     beat_idx  <= next_idx;
                     beat_data <= beats[next_idx];
                     beat_last <= (next_idx == last_idx);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_frame_unpacker.sv
// Bench for fifo_frame_unpacker: FIFO model on the read side, expected-beat queue
// built from each popped word, checked every cycle.
module tb_fifo_frame_unpacker;
   localparam int DATA_W    = 140;
   localparam int BEAT_W    = 16;
   localparam int MAX_BEATS = 8;
   localparam int CNT_W     = 16;

   logic              clk_out = 1'b0;
   logic              rst_n = 1'b0;
   logic              fifo_empty = 1'b1;
   logic              fifo_r_enable;
   logic [DATA_W-1:0] data_from_fifo = '0;
   logic [BEAT_W-1:0] beat_data;
   logic [7:0]        beat_chan;
   logic              beat_last;
   logic              beat_valid;
   logic              beat_ready = 1'b0;
   logic [CNT_W-1:0]  frame_cnt;
   logic [CNT_W-1:0]  len_err_cnt;
   logic              len_err;

   always #5 clk_out = ~clk_out;

   fifo_frame_unpacker #(
      .DATA_W(DATA_W), .BEAT_W(BEAT_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
   ) dut (
      .clk_out(clk_out), .rst_n(rst_n), .fifo_empty(fifo_empty),
      .fifo_r_enable(fifo_r_enable), .data_from_fifo(data_from_fifo),
      .beat_data(beat_data), .beat_chan(beat_chan), .beat_last(beat_last),
      .beat_valid(beat_valid), .beat_ready(beat_ready), .frame_cnt(frame_cnt),
      .len_err_cnt(len_err_cnt), .len_err(len_err)
   );

   typedef struct packed {
      logic [BEAT_W-1:0] data;
      logic [7:0]        chan;
      logic              last;
   } beat_t;

   typedef struct {
      logic [3:0] len;
      logic [7:0] chan;
      int         exp_beats;
      int         exp_errs;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DATA_W-1:0] fifo_q[$];
   beat_t             exp_q[$];
   int                exp_frames = 0;
   logic [CNT_W-1:0]  exp_errs = '0;
   logic              exp_len_err = 1'b0;
   logic              pop_prev = 1'b0;

   int cyc = 0, beats_seen = 0, err_seen = 0, pops = 0, pop_cyc = 0, rise_cyc = 0;
   logic              prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b0, prev_last = 1'b0;
   logic [BEAT_W-1:0] prev_data = '0;
   logic [7:0]        prev_chan = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DATA_W-1:0] make_word(input logic [3:0] len, input logic [7:0] chan);
      return {len, chan, $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Expected behaviour of one popped word, straight from the frame format.
   task automatic model_word(input logic [DATA_W-1:0] w);
      int n;
      beat_t b;
      logic [DATA_W-1:0] sh;
      n = int'(w[DATA_W-1 -: 4]);
      if (n < 1 || n > MAX_BEATS) begin
         exp_len_err = 1'b1;
         if (exp_errs != '1) exp_errs++;
      end else begin
         for (int i = 0; i < n; i++) begin
            sh     = w >> (BEAT_W * i);
            b.data = sh[BEAT_W-1:0];
            b.chan = w[DATA_W-5 -: 8];
            b.last = (i == n - 1);
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic step(input logic rdy, input logic rst_v);
      logic [DATA_W-1:0] arrived;
      logic got, busy, exp_ren;
      beat_t b;
      @(negedge clk_out);
      cyc++;
      got = 1'b0;
      arrived = '0;
      if (pop_prev && fifo_q.size() > 0) begin
         arrived = fifo_q.pop_front();
         data_from_fifo = arrived;
         got = 1'b1;
      end
      rst_n      = rst_v;
      beat_ready = rdy;
      fifo_empty = (fifo_q.size() == 0);
      #1;
      check("beat_valid", beat_valid, exp_q.size() > 0);
      check("frame_cnt", frame_cnt, CNT_W'(exp_frames));
      check("len_err_cnt", len_err_cnt, exp_errs);
      check("len_err", len_err, exp_len_err);
      busy    = pop_prev || (exp_q.size() > 0);
      exp_ren = rst_v && !fifo_empty && (!busy || (exp_q.size() == 1 && rdy));
      check("fifo_r_enable", fifo_r_enable, exp_ren);
      if (!beat_valid) check("beat_last_idle", beat_last, 1'b0);
      if (prev_rst && prev_valid && !prev_ready) begin
         check("stall_valid", beat_valid, 1'b1);
         check("stall_data", beat_data, prev_data);
         check("stall_chan", beat_chan, prev_chan);
         check("stall_last", beat_last, prev_last);
      end
      if (rst_v && beat_valid && rdy) begin
         beats_seen++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got data %0h, expected no beat (cycle %0d)", beat_data, cyc);
         end else begin
            b = exp_q.pop_front();
            check("beat_data", beat_data, b.data);
            check("beat_chan", beat_chan, b.chan);
            check("beat_last", beat_last, b.last);
            if (b.last) exp_frames++;
         end
      end
      if (len_err) err_seen++;
      if (fifo_r_enable) begin
         pops++;
         pop_cyc = cyc;
      end
      if (beat_valid && !prev_valid) rise_cyc = cyc;
      exp_len_err = 1'b0;
      if (got) model_word(arrived);
      if (!rst_v) begin
         exp_q.delete();
         exp_frames  = 0;
         exp_errs    = '0;
         exp_len_err = 1'b0;
      end
      prev_valid = beat_valid;
      prev_ready = rdy;
      prev_rst   = rst_v;
      prev_data  = beat_data;
      prev_chan  = beat_chan;
      prev_last  = beat_last;
      pop_prev   = fifo_r_enable;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      int b0, e0, p0, f0, k;
      logic drained;
      logic [DATA_W-1:0] w;
      logic [3:0] rl;
      int r;

      vecs[0] = '{len: 4'd3,  chan: 8'hA5, exp_beats: 3, exp_errs: 0};
      vecs[1] = '{len: 4'd8,  chan: 8'h3C, exp_beats: 8, exp_errs: 0};
      vecs[2] = '{len: 4'd1,  chan: 8'h01, exp_beats: 1, exp_errs: 0};
      vecs[3] = '{len: 4'd0,  chan: 8'h77, exp_beats: 0, exp_errs: 1};
      vecs[4] = '{len: 4'd9,  chan: 8'h88, exp_beats: 0, exp_errs: 1};
      vecs[5] = '{len: 4'd15, chan: 8'hFF, exp_beats: 0, exp_errs: 1};
      vecs[6] = '{len: 4'd2,  chan: 8'h42, exp_beats: 2, exp_errs: 0};

      // Reset held with a word waiting in the FIFO
      fifo_q.push_back(make_word(4'd3, 8'hA5));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      check("rst_beat_data", beat_data, '0);
      check("rst_beat_chan", beat_chan, '0);
      check("rst_frame_cnt", frame_cnt, '0);
      check("rst_len_err_cnt", len_err_cnt, '0);

      // Single frame, n=3
      b0 = beats_seen;
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
      check("single_beats", beats_seen - b0, 3);
      check("single_frame_cnt", frame_cnt, 1);
      check("single_latency", rise_cyc - pop_cyc, 2);

      // Backpressure on an 8-beat frame followed by a 1-beat frame
      fifo_q.push_back(make_word(4'd8, 8'hC3));
      fifo_q.push_back(make_word(4'd1, 8'h11));
      b0 = beats_seen; p0 = pops;
      for (int i = 0; i < 30; i++) step((i % 2) == 0, 1'b1);
      check("bp_beats", beats_seen - b0, 9);
      check("bp_pops", pops - p0, 2);
      check("bp_frame_cnt", frame_cnt, 3);

      // Back-to-back single-beat frames
      for (int i = 0; i < 3; i++) fifo_q.push_back(make_word(4'd1, 8'(8'h20 + i)));
      b0 = beats_seen; p0 = pops;
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
      check("b2b_beats", beats_seen - b0, 3);
      check("b2b_pops", pops - p0, 3);
      check("b2b_frame_cnt", frame_cnt, 6);

      // Bad lengths queued ahead of a good frame
      fifo_q.push_back(make_word(4'd0, 8'h90));
      fifo_q.push_back(make_word(4'd9, 8'h91));
      fifo_q.push_back(make_word(4'd2, 8'h92));
      b0 = beats_seen; e0 = err_seen;
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
      check("bad_err_pulses", err_seen - e0, 2);
      check("bad_len_err_cnt", len_err_cnt, 2);
      check("bad_beats", beats_seen - b0, 2);

      // One frame at a time from the vector table
      for (int v = 0; v < 7; v++) begin
         b0 = beats_seen; e0 = err_seen; f0 = int'(len_err_cnt);
         fifo_q.push_back(make_word(vecs[v].len, vecs[v].chan));
         for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
         check("vec_beats", beats_seen - b0, vecs[v].exp_beats);
         check("vec_err_pulses", err_seen - e0, vecs[v].exp_errs);
         check("vec_len_err_cnt", int'(len_err_cnt) - f0, vecs[v].exp_errs);
      end

      // Reset in the middle of a 5-beat frame
      fifo_q.push_back(make_word(4'd5, 8'h5A));
      fifo_q.push_back(make_word(4'd2, 8'hB2));
      b0 = beats_seen;
      k = 0;
      while (beats_seen == b0 && k < 10) begin
         step(1'b1, 1'b1);
         k++;
      end
      check("mid_first_beat_seen", beats_seen - b0, 1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      check("mid_valid_after_rst", beat_valid, 1'b0);
      check("mid_frame_cnt_cleared", frame_cnt, 0);
      b0 = beats_seen;
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
      check("mid_next_beats", beats_seen - b0, 2);
      check("mid_next_frame_cnt", frame_cnt, 1);

      // Random traffic, random backpressure, rare resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 4) begin
            r = $urandom_range(0, 9);
            if (r == 9) rl = 4'($urandom_range(9, 15));
            else rl = 4'(r);
            fifo_q.push_back(make_word(rl, 8'($urandom())));
         end
         step($urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
      end

      drained = 1'b0;
      for (int i = 0; i < 200 && !drained; i++) begin
         step(1'b1, 1'b1);
         drained = (fifo_q.size() == 0) && (exp_q.size() == 0) && !pop_prev;
      end
      check("drain_complete", drained, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
